// File: rtl/sha256_pkg.sv
// Shared constants and FSM state type for the SHA-256 round controller.
package sha256_pkg;
    localparam int unsigned NUM_ROUNDS  = 64;
    localparam int unsigned MSG_WORDS   = 16;
    localparam int unsigned ROUND_IDX_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_UPDATE,
        ST_DIGEST
    } state_t;
endpackage

// File: rtl/sha256_round_cnt.sv
// Round index counter: counts 0..NUM_ROUNDS-1 while enabled, wraps to 0,
// flags the terminal round.
module sha256_round_cnt
    import sha256_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   en,
    output logic [ROUND_IDX_W-1:0] idx,
    output logic                   tc
);

    assign tc = (idx == ROUND_IDX_W'(NUM_ROUNDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (en) begin
            idx <= tc ? '0 : idx + ROUND_IDX_W'(1);
        end
    end

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: accepts a block, loads working vars, runs
// 64 rounds, folds into H and presents the digest after the last block.
module sha256_round_ctrl
    import sha256_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       blk_valid,
    output logic       blk_ready,
    input  logic       blk_first,
    input  logic       blk_last,
    output logic       wv_load,
    output logic       iv_sel,
    output logic       round_en,
    output logic [5:0] round_idx,
    output logic       w_from_msg,
    output logic       h_update,
    output logic       digest_valid,
    input  logic       digest_ready,
    output logic       busy
);

    state_t state;
    state_t state_nxt;
    logic   first_q;
    logic   last_q;
    logic   have_hash;
    logic   accept;
    logic   cnt_tc;

    sha256_round_cnt u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .en    (state == ST_ROUND),
        .idx   (round_idx),
        .tc    (cnt_tc)
    );

    assign accept = blk_valid && (state == ST_IDLE) && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (blk_valid) state_nxt = ST_LOAD;
            ST_LOAD:   state_nxt = ST_ROUND;
            ST_ROUND:  if (cnt_tc) state_nxt = ST_UPDATE;
            ST_UPDATE: state_nxt = last_q ? ST_DIGEST : ST_IDLE;
            ST_DIGEST: if (digest_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (clear) begin
            state_nxt = ST_IDLE;
        end
    end

    // have_hash=0 means H is not a valid chaining value, so the next block must start from IV.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            have_hash <= 1'b0;
        end else if (clear) begin
            have_hash <= 1'b0;
        end else begin
            if (accept) begin
                first_q <= blk_first | ~have_hash;
                last_q  <= blk_last;
            end
            if (state == ST_UPDATE) begin
                have_hash <= 1'b1;
            end else if (state == ST_DIGEST && digest_ready) begin
                have_hash <= 1'b0;
            end
        end
    end

    always_comb begin
        blk_ready    = 1'b0;
        wv_load      = 1'b0;
        iv_sel       = 1'b0;
        round_en     = 1'b0;
        w_from_msg   = 1'b0;
        h_update     = 1'b0;
        digest_valid = 1'b0;
        busy         = (state != ST_IDLE);
        case (state)
            ST_IDLE:   blk_ready = 1'b1;
            ST_LOAD: begin
                wv_load = 1'b1;
                iv_sel  = first_q;
            end
            ST_ROUND: begin
                round_en   = 1'b1;
                w_from_msg = (round_idx < ROUND_IDX_W'(MSG_WORDS));
            end
            ST_UPDATE: h_update = 1'b1;
            ST_DIGEST: digest_valid = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: doc/sha256_round_ctrl.md
SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Ports SHALL be as follows:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous abort to IDLE
- blk_valid  input  1  a 512-bit message block is presented
- blk_ready  output  1  controller can accept a block
- blk_first  input  1  block starts a new message; sampled on accept
- blk_last  input  1  block ends the message; sampled on accept
- wv_load  output  1  load working vars a..h
- iv_sel  output  1  with wv_load: load H and a..h from IV, not from H
- round_en  output  1  execute one compression round (Ch, Ma, Sigma adders)
- round_idx  output  6  round t, 0..63; selects K[t]
- w_from_msg  output  1  W[t] taken from the block (t<16), else expanded
- h_update  output  1  H[i] <= H[i] + working var
- digest_valid  output  1  H holds the final digest
- digest_ready  input  1  digest consumed
- busy  output  1  state != IDLE

Function
REQ-003 States SHALL be IDLE, LOAD, ROUND, UPDATE and DIGEST.
REQ-004 In IDLE, blk_ready SHALL be 1; in every other state it SHALL be 0.
REQ-005 Accept SHALL occur when blk_valid & blk_ready; on accept, first_q <= blk_first | ~have_hash, last_q <= blk_last, and the next state SHALL be LOAD.
REQ-006 LOAD SHALL last exactly 1 cycle with wv_load=1 and iv_sel=first_q, then go to ROUND with round_idx=0.
REQ-007 ROUND SHALL last exactly 64 cycles with round_en=1, round_idx incrementing 0..63, and w_from_msg=1 when round_idx<16.
REQ-008 At round_idx=63, the next state SHALL be UPDATE and round_idx SHALL wrap to 0.
REQ-009 UPDATE SHALL last 1 cycle with h_update=1 and SHALL set have_hash=1; the next state SHALL be DIGEST if last_q, else IDLE.
REQ-010 DIGEST SHALL hold digest_valid=1 until digest_ready=1, then go to IDLE and clear have_hash.
REQ-011 Fixed latency SHALL be: accept at cycle N, LOAD at N+1, rounds at N+2..N+65, UPDATE at N+66, digest_valid from N+67 (last block), or blk_ready=1 at N+67 (non-last block).
REQ-012 digest_ready=1 on the first DIGEST cycle SHALL exit at the next edge (digest_valid is high exactly 1 cycle).
REQ-013 blk_valid, blk_first and blk_last outside IDLE SHALL be ignored.
REQ-014 A first block arriving with blk_first=0 after reset, clear or a completed digest SHALL still force iv_sel=1 (via have_hash=0).
REQ-015 clear SHALL take priority over every transition: the next state SHALL be IDLE, round_idx=0, have_hash=0, and all strobes 0 from the next cycle.
REQ-016 wv_load, round_en, h_update and digest_valid SHALL be mutually exclusive, decoded from the registered state only (no input-to-output combinational paths except none).

Reset
REQ-017 On rst_n=0, state SHALL be IDLE, round_idx=0, first_q=last_q=have_hash=0 and all strobes 0, with blk_ready=1 and busy=0, immediately and independently of clk.
REQ-018 Reset deassertion SHALL take effect at the first rising clk edge at which rst_n=1; no block SHALL be accepted in the same cycle as reset release.
REQ-019 Reset mid-ROUND SHALL abandon the block; H contents are then invalid and the next block SHALL use IV (per REQ-014).

Structure
REQ-020 Package sha256_pkg SHALL hold the state encoding, NUM_ROUNDS=64, MSG_WORDS=16 and ROUND_IDX_W=6.
REQ-021 The 6-bit round counter with wrap and terminal-count flag SHALL be a sub-module, sha256_round_cnt; the FSM and flags live in sha256_round_ctrl.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Single-block message: blk_valid=1, first=1, last=1 at cycle 5 -> wv_load&iv_sel at 6; round_en at 7..70 with round_idx 0..63; w_from_msg at 7..22; h_update at 71; digest_valid at 72.
- Two-block message: second block with first=0, last=1 presented at blk_ready -> second LOAD has iv_sel=0; digest_valid only after the second UPDATE.
- Backpressure: digest_ready held 0 for 10 cycles -> digest_valid stays 1 and blk_ready stays 0; ready=1 -> IDLE next cycle.
- clear at round_idx=30 -> next cycle IDLE, round_idx=0, round_en=0; next block forces iv_sel=1 even with first=0.
- Asynchronous rst_n pulse between edges during ROUND -> outputs reach reset values without a clock edge; blk_valid held during reset release is not accepted until the first edge after rst_n=1.
- blk_valid toggled during ROUND -> no effect on state or round_idx; strobe exclusivity asserted every cycle.
